// File: rtl/tt_um_jimktrains_vslc_servo_timebase_if.sv
// Host configuration write bus for the servo timebase.
// The host drives it through the master modport; the timebase samples it through slave.
interface tt_um_jimktrains_vslc_servo_timebase_if;
  logic       cfg_we;
  logic [2:0] cfg_addr;
  logic [7:0] cfg_wdata;

  modport master (output cfg_we, cfg_addr, cfg_wdata);
  modport slave  (input  cfg_we, cfg_addr, cfg_wdata);
endinterface

// File: rtl/tt_um_jimktrains_vslc_servo_timebase.sv
// Servo timebase: shadow config bank, tick prescaler and frame counter.
// While running, new settings are committed only at a frame boundary.
module tt_um_jimktrains_vslc_servo_timebase #(
  parameter int PRESCALE_W = 16  // byte map needs at least 16 bits
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  tt_um_jimktrains_vslc_servo_timebase_if.slave cfg,
  output logic                                  servo_clk,
  output logic [4:0]                            servo_set_val,
  output logic [4:0]                            servo_reset_val,
  output logic [7:0]                            servo_freq_val,
  output logic                                  servo_enabled,
  output logic                                  frame_start,
  output logic                                  cfg_pending
);

  logic [PRESCALE_W-1:0] presc_sh_r, presc_r, presc_cnt_r, presc_cnt_next_s;
  logic [4:0]            set_sh_r, reset_sh_r, set_r, reset_r;
  logic [7:0]            freq_sh_r, freq_r, frame_cnt_r, frame_cnt_next_s;
  logic                  en_sh_r, enabled_r, servo_clk_r, frame_start_r, pending_r;
  logic                  wr_valid_s, tick_end_s, commit_s, en_next_s, servo_clk_next_s;

  // A zero prescale would leave no low cycle between ticks
  function automatic logic [PRESCALE_W-1:0] clamp_presc(input logic [PRESCALE_W-1:0] v);
    if (v == '0) begin
      return PRESCALE_W'(1);
    end else begin
      return v;
    end
  endfunction

  // Commit decision and next values for the prescaler / frame counter
  always_comb begin
    wr_valid_s       = cfg.cfg_we && (cfg.cfg_addr <= 3'd5);
    tick_end_s       = servo_clk_r && (frame_cnt_r == freq_r);
    commit_s         = pending_r && (!enabled_r || !en_sh_r || tick_end_s);
    en_next_s        = commit_s ? en_sh_r : enabled_r;
    presc_cnt_next_s = '0;
    frame_cnt_next_s = 8'd0;
    servo_clk_next_s = 1'b0;
    // Counters only run while enabled both before and after this edge;
    // enabling, disabling or staying off all restart them from zero.
    if (enabled_r && en_next_s) begin
      if (presc_cnt_r == presc_r) begin
        presc_cnt_next_s = '0;
        servo_clk_next_s = 1'b1;
      end else begin
        presc_cnt_next_s = presc_cnt_r + PRESCALE_W'(1);
        servo_clk_next_s = 1'b0;
      end
      if (servo_clk_r) begin
        frame_cnt_next_s = tick_end_s ? 8'd0 : frame_cnt_r + 8'd1;
      end else begin
        frame_cnt_next_s = frame_cnt_r;
      end
    end else begin
      presc_cnt_next_s = '0;
      frame_cnt_next_s = 8'd0;
      servo_clk_next_s = 1'b0;
    end
  end

  // Host writes land in the shadow bank
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_sh_r <= '0;
      set_sh_r   <= 5'd0;
      reset_sh_r <= 5'd0;
      freq_sh_r  <= 8'd0;
      en_sh_r    <= 1'b0;
    end else if (wr_valid_s) begin
      case (cfg.cfg_addr)
        3'd0:    presc_sh_r[7:0]  <= cfg.cfg_wdata;
        3'd1:    presc_sh_r[15:8] <= cfg.cfg_wdata;
        3'd2:    set_sh_r         <= cfg.cfg_wdata[4:0];
        3'd3:    reset_sh_r       <= cfg.cfg_wdata[4:0];
        3'd4:    freq_sh_r        <= cfg.cfg_wdata;
        3'd5:    en_sh_r          <= cfg.cfg_wdata[0];
        default: ;
      endcase
    end
  end

  // Commit copies the pre-edge shadow; a same-edge write keeps pending set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_r   <= '0;
      set_r     <= 5'd0;
      reset_r   <= 5'd0;
      freq_r    <= 8'd0;
      enabled_r <= 1'b0;
      pending_r <= 1'b0;
    end else begin
      if (commit_s) begin
        presc_r   <= clamp_presc(presc_sh_r);
        set_r     <= set_sh_r;
        reset_r   <= reset_sh_r;
        freq_r    <= freq_sh_r;
        enabled_r <= en_sh_r;
      end
      if (wr_valid_s) begin
        pending_r <= 1'b1;
      end else if (commit_s) begin
        pending_r <= 1'b0;
      end
    end
  end

  // Tick generator, frame counter and frame-start pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_cnt_r   <= '0;
      frame_cnt_r   <= 8'd0;
      servo_clk_r   <= 1'b0;
      frame_start_r <= 1'b0;
    end else begin
      presc_cnt_r   <= presc_cnt_next_s;
      frame_cnt_r   <= frame_cnt_next_s;
      servo_clk_r   <= servo_clk_next_s;
      frame_start_r <= tick_end_s;
    end
  end

  assign servo_clk       = servo_clk_r;
  assign servo_set_val   = set_r;
  assign servo_reset_val = reset_r;
  assign servo_freq_val  = freq_r;
  assign servo_enabled   = enabled_r;
  assign frame_start     = frame_start_r;
  assign cfg_pending     = pending_r;

endmodule

// File: tb/tb_tt_um_jimktrains_vslc_servo_timebase.sv
// Self-checking bench for the servo timebase: directed table, corner sequences,
// and a randomized run against an event-scheduled reference model.
module tb_tt_um_jimktrains_vslc_servo_timebase;
  logic       clk;
  logic       rst_n;
  logic       servo_clk, servo_enabled, frame_start, cfg_pending;
  logic [4:0] servo_set_val, servo_reset_val;
  logic [7:0] servo_freq_val;

  tt_um_jimktrains_vslc_servo_timebase_if cfg_bus ();

  tt_um_jimktrains_vslc_servo_timebase #(.PRESCALE_W(16)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cfg            (cfg_bus),
    .servo_clk      (servo_clk),
    .servo_set_val  (servo_set_val),
    .servo_reset_val(servo_reset_val),
    .servo_freq_val (servo_freq_val),
    .servo_enabled  (servo_enabled),
    .frame_start    (frame_start),
    .cfg_pending    (cfg_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: committed config plus an absolute-cycle tick schedule
  typedef struct packed {
    logic [15:0] presc;
    logic [4:0]  set_v;
    logic [4:0]  reset_v;
    logic [7:0]  freq;
    logic        en;
  } cfg_t;

  cfg_t m_sh, m_cm;
  bit   m_pending, m_clk, m_fstart, m_resched;
  int   m_fpos, m_next_tick, cyc;

  task automatic model_reset();
    m_sh = '0; m_cm = '0;
    m_pending = 0; m_clk = 0; m_fstart = 0; m_resched = 0;
    m_fpos = 0; m_next_tick = 0;
  endtask

  task automatic model_edge(input bit we, input logic [2:0] addr, input logic [7:0] data);
    bit c_evt, commit, was_en;
    c_evt  = m_clk && (m_fpos == int'(m_cm.freq));
    commit = m_pending && (!m_cm.en || !m_sh.en || c_evt);
    was_en = m_cm.en;
    cyc++;
    if (commit) begin
      m_cm = m_sh;
      if (m_cm.presc == 16'd0) m_cm.presc = 16'd1;
    end
    if (we && addr <= 3'd5) begin
      case (addr)
        3'd0: m_sh.presc[7:0]  = data;
        3'd1: m_sh.presc[15:8] = data;
        3'd2: m_sh.set_v       = data[4:0];
        3'd3: m_sh.reset_v     = data[4:0];
        3'd4: m_sh.freq        = data;
        default: m_sh.en       = data[0];
      endcase
      m_pending = 1;
    end else if (commit) begin
      m_pending = 0;
    end
    m_fstart = c_evt;
    if (was_en && m_cm.en) begin
      if (m_clk) m_fpos = c_evt ? 0 : m_fpos + 1;
      if (m_resched) begin
        m_next_tick = cyc + int'(m_cm.presc);
        m_resched = 0;
      end
      m_clk = (cyc == m_next_tick);
      if (m_clk) m_resched = 1;
    end else begin
      m_clk = 0; m_fpos = 0; m_resched = 0;
      m_next_tick = cyc + int'(m_cm.presc) + 1;
    end
  endtask

  // One clock: drive at negedge, model at posedge, compare at next negedge
  task automatic do_cycle(input bit we, input logic [2:0] addr, input logic [7:0] data);
    cfg_bus.cfg_we    = we;
    cfg_bus.cfg_addr  = addr;
    cfg_bus.cfg_wdata = data;
    @(posedge clk);
    model_edge(we, addr, data);
    @(negedge clk);
    chk("m_servo_clk", servo_clk, m_clk);
    chk("m_set", servo_set_val, m_cm.set_v);
    chk("m_reset", servo_reset_val, m_cm.reset_v);
    chk("m_freq", servo_freq_val, m_cm.freq);
    chk("m_enabled", servo_enabled, m_cm.en);
    chk("m_frame_start", frame_start, m_fstart);
    chk("m_pending", cfg_pending, m_pending);
    chk("m_frame_cnt", dut.frame_cnt_r, m_fpos);
  endtask

  typedef struct {
    bit         we;
    logic [2:0] addr;
    logic [7:0] data;
    logic [4:0] e_set;
    logic [4:0] e_rst;
    logic [7:0] e_freq;
    bit         e_en;
    bit         e_pend;
    bit         e_clk;
  } vec_t;

  vec_t tbl[14];

  initial begin
    int e0, fs1, fs2, highs, consec;
    bit found, prev;
    cfg_bus.cfg_we = 1'b0; cfg_bus.cfg_addr = 3'd0; cfg_bus.cfg_wdata = 8'd0;
    cyc = 0;
    model_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_enabled", servo_enabled, 1'b0);
    chk("rst_pending", cfg_pending, 1'b0);

    // Disabled configuration: each write commits one edge later
    tbl[0]  = '{1'b1, 3'd0, 8'h03, 5'd0, 5'd0,  8'h00, 1'b0, 1'b1, 1'b0};
    tbl[1]  = '{1'b1, 3'd2, 8'hE5, 5'd0, 5'd0,  8'h00, 1'b0, 1'b1, 1'b0};
    tbl[2]  = '{1'b1, 3'd3, 8'hEA, 5'd5, 5'd0,  8'h00, 1'b0, 1'b1, 1'b0};
    tbl[3]  = '{1'b1, 3'd4, 8'h13, 5'd5, 5'd10, 8'h00, 1'b0, 1'b1, 1'b0};
    tbl[4]  = '{1'b1, 3'd5, 8'h01, 5'd5, 5'd10, 8'h13, 1'b0, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 3'd0, 8'h00, 5'd5, 5'd10, 8'h13, 1'b1, 1'b0, 1'b0};
    for (int i = 6; i < 14; i++)
      tbl[i] = '{1'b0, 3'd0, 8'h00, 5'd5, 5'd10, 8'h13, 1'b1, 1'b0, (i == 9 || i == 13)};
    e0 = 0;
    for (int i = 0; i < 14; i++) begin
      do_cycle(tbl[i].we, tbl[i].addr, tbl[i].data);
      chk("tbl_set", servo_set_val, tbl[i].e_set);
      chk("tbl_reset", servo_reset_val, tbl[i].e_rst);
      chk("tbl_freq", servo_freq_val, tbl[i].e_freq);
      chk("tbl_enabled", servo_enabled, tbl[i].e_en);
      chk("tbl_pending", cfg_pending, tbl[i].e_pend);
      chk("tbl_servo_clk", servo_clk, tbl[i].e_clk);
      if (i == 5) e0 = cyc;
    end

    // Frame alignment: P=3, F=19 gives an 80-cycle frame
    fs1 = -1; fs2 = -1;
    for (int i = 0; i < 300 && fs2 < 0; i++) begin
      do_cycle(1'b0, 3'd0, 8'h00);
      if (frame_start) begin
        if (fs1 < 0) fs1 = cyc; else fs2 = cyc;
      end
    end
    chk("frame_first", fs1 - e0, 32'd81);
    chk("frame_period", fs2 - fs1, 32'd80);

    // Deferred commit of a mid-frame write
    repeat (10) do_cycle(1'b0, 3'd0, 8'h00);
    do_cycle(1'b1, 3'd2, 8'h08);
    chk("defer_hold", servo_set_val, 5'd5);
    chk("defer_pend1", cfg_pending, 1'b1);
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      do_cycle(1'b0, 3'd0, 8'h00);
      if (servo_set_val == 5'd8) begin
        found = 1;
        chk("defer_fstart", frame_start, 1'b1);
        chk("defer_pend0", cfg_pending, 1'b0);
      end
    end
    chk("defer_seen", found, 1'b1);

    // Write colliding with a boundary commit
    repeat (5) do_cycle(1'b0, 3'd0, 8'h00);
    do_cycle(1'b1, 3'd3, 8'h07);
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (m_clk && m_fpos == int'(m_cm.freq)) found = 1;
      else do_cycle(1'b0, 3'd0, 8'h00);
    end
    chk("coll_wait", found, 1'b1);
    do_cycle(1'b1, 3'd3, 8'h0C);
    chk("coll_reset", servo_reset_val, 5'd7);
    chk("coll_pend", cfg_pending, 1'b1);
    chk("coll_fstart", frame_start, 1'b1);

    // Immediate disable mid-frame
    repeat (10) do_cycle(1'b0, 3'd0, 8'h00);
    do_cycle(1'b1, 3'd5, 8'h00);
    chk("dis_still_on", servo_enabled, 1'b1);
    do_cycle(1'b0, 3'd0, 8'h00);
    chk("dis_off", servo_enabled, 1'b0);
    chk("dis_reset", servo_reset_val, 5'd12);
    chk("dis_clk", servo_clk, 1'b0);
    chk("dis_presc_cnt", dut.presc_cnt_r, 32'd0);
    chk("dis_frame_cnt", dut.frame_cnt_r, 32'd0);

    // Prescale of zero clamps to a 2-cycle tick period
    do_cycle(1'b1, 3'd0, 8'h00);
    do_cycle(1'b1, 3'd1, 8'h00);
    do_cycle(1'b1, 3'd5, 8'h01);
    do_cycle(1'b0, 3'd0, 8'h00);
    chk("clamp_en", servo_enabled, 1'b1);
    highs = 0; consec = 0; prev = 0;
    for (int i = 0; i < 20; i++) begin
      do_cycle(1'b0, 3'd0, 8'h00);
      if (servo_clk) highs++;
      if (servo_clk && prev) consec++;
      prev = servo_clk;
    end
    chk("clamp_count", highs, 32'd10);
    chk("clamp_consec", consec, 32'd0);

    // Asynchronous reset while running
    #2 rst_n = 1'b0;
    #1;
    chk("arst_clk", servo_clk, 1'b0);
    chk("arst_en", servo_enabled, 1'b0);
    chk("arst_set", servo_set_val, 5'd0);
    chk("arst_reset", servo_reset_val, 5'd0);
    chk("arst_freq", servo_freq_val, 8'd0);
    chk("arst_fstart", frame_start, 1'b0);
    chk("arst_pend", cfg_pending, 1'b0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    highs = 0;
    for (int i = 0; i < 100; i++) begin
      do_cycle(1'b0, 3'd0, 8'h00);
      if (servo_clk || cfg_pending) highs++;
    end
    chk("post_rst_quiet", highs, 32'd0);

    // Randomized traffic against the model
    do_cycle(1'b1, 3'd5, 8'h01);
    for (int i = 0; i < 3000; i++) begin
      logic [2:0] a;
      logic [7:0] d;
      if ($urandom_range(0, 19) == 0) begin
        a = 3'($urandom_range(0, 7));
        case (a)
          3'd0:    d = 8'($urandom_range(0, 6));
          3'd1:    d = ($urandom_range(0, 9) == 0) ? 8'd1 : 8'd0;
          3'd4:    d = 8'($urandom_range(0, 12));
          3'd5:    d = {7'($urandom), 1'($urandom_range(0, 3) != 0)};
          default: d = 8'($urandom);
        endcase
        do_cycle(1'b1, a, d);
      end else begin
        do_cycle(1'b0, 3'd0, 8'h00);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
